// File: rtl/hanoi_pkg.sv
// hanoi_pkg: shared types and helpers for the Tower-of-Hanoi engine
package hanoi_pkg;
  localparam int SMAX = 8;
  typedef enum logic [1:0] {ERR_OK, ERR_EMPTY, ERR_SIZE, ERR_PEG} err_e;
  typedef enum logic [1:0] {IDLE, MANUAL, AUTO, DONE} state_e;
  function automatic logic [SMAX-1:0] top_disk(input logic [SMAX-1:0] m);
    return m & (~m + SMAX'(1));
  endfunction
endpackage

// File: rtl/hanoi_move_check.sv
// hanoi_move_check: combinational legality check and mask update for one move
module hanoi_move_check import hanoi_pkg::*; #(
  parameter int S  = 3,
  parameter int P  = 3,
  parameter int PW = $clog2(P)
) (
  input  logic [P-1:0][S-1:0] pegs_i,
  input  logic [PW-1:0]       from_i,
  input  logic [PW-1:0]       to_i,
  output logic                legal_o,
  output err_e                err_o,
  output logic [S-1:0]        from_mask_o,
  output logic [S-1:0]        to_mask_o
);
  logic bad;
  logic [PW-1:0] fi, ti;
  logic [S-1:0] src, dst, tf, tt;
  always_comb begin
    bad = from_i == to_i || from_i > PW'(P-1) || to_i > PW'(P-1);
    fi = bad ? '0 : from_i;
    ti = bad ? '0 : to_i;
    src = pegs_i[fi];
    dst = pegs_i[ti];
    tf = S'(top_disk(SMAX'(src)));
    tt = S'(top_disk(SMAX'(dst)));
    // one-hot tops compare numerically as disk sizes
    err_o = bad ? ERR_PEG : src == '0 ? ERR_EMPTY : (dst != '0 && tf > tt) ? ERR_SIZE : ERR_OK;
    legal_o = err_o == ERR_OK;
    from_mask_o = src & ~tf;
    to_mask_o = dst | tf;
  end
endmodule

// File: rtl/hanoi_engine.sv
// hanoi_engine: Tower-of-Hanoi state engine with checked manual moves and an iterative auto solver
module hanoi_engine import hanoi_pkg::*; #(
  parameter int S   = 3,
  parameter int P   = 3,
  parameter int TGT = P-1,
  parameter int PW  = $clog2(P),
  parameter int CW  = S+1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode_i,
  input  logic           start_i,
  input  logic           mv_valid_i,
  output logic           mv_ready_o,
  input  logic [PW-1:0]  mv_from_i,
  input  logic [PW-1:0]  mv_to_i,
  output logic           rsp_valid_o,
  output logic           rsp_legal_o,
  output logic [1:0]     rsp_err_o,
  output logic [P*S-1:0] peg_state_o,
  output logic [CW-1:0]  move_cnt_o,
  output logic           solved_o,
  output logic           busy_o
);
  localparam int AUX = TGT == 1 ? 2 : 1;
  localparam int PS = P*S;
  localparam logic [PW-1:0] PZ = '0;
  localparam logic [PW-1:0] PA = PW'(AUX);
  localparam logic [PW-1:0] PT = PW'(TGT);
  localparam logic [CW-1:0] LAST = CW'((1 << S) - 2);
  localparam logic [P-1:0][S-1:0] INIT = PS'({S{1'b1}});
  state_e state_q, state_d;
  logic [P-1:0][S-1:0] pegs_q, pegs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rv_q, rv_d, rl_q, rl_d;
  err_e re_q, re_d;
  logic [PW-1:0] sp, nx, oa, ob, af, at, cf, ct;
  logic a2b, acc, legal;
  err_e err;
  logic [S-1:0] fm, tm, seen, dup;
  // Auto move: odd moves rotate the smallest disk, even moves make the only other legal move
  always_comb begin
    sp = pegs_q[0][0] ? PZ : pegs_q[AUX][0] ? PA : PT;
    nx = (S % 2 == 0) ? (sp == PZ ? PA : sp == PA ? PT : PZ)
                      : (sp == PZ ? PT : sp == PT ? PA : PZ);
    oa = sp == PZ ? PA : PZ;
    ob = sp == PT ? PA : PT;
    a2b = pegs_q[oa] != '0 && (pegs_q[ob] == '0 ||
          top_disk(SMAX'(pegs_q[oa])) < top_disk(SMAX'(pegs_q[ob])));
    af = ~cnt_q[0] ? sp : a2b ? oa : ob;
    at = ~cnt_q[0] ? nx : a2b ? ob : oa;
    cf = state_q == AUTO ? af : mv_from_i;
    ct = state_q == AUTO ? at : mv_to_i;
  end
  hanoi_move_check #(.S(S), .P(P), .PW(PW)) u_chk (
    .pegs_i(pegs_q), .from_i(cf), .to_i(ct),
    .legal_o(legal), .err_o(err), .from_mask_o(fm), .to_mask_o(tm)
  );
  always_comb begin
    acc = state_q == AUTO || (state_q == MANUAL && mv_valid_i);
    state_d = state_q;
    pegs_d = pegs_q;
    cnt_d = cnt_q;
    rv_d = acc;
    rl_d = acc && legal;
    re_d = acc ? err : ERR_OK;
    if (acc && legal) begin
      pegs_d[cf] = fm;
      pegs_d[ct] = tm;
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start_i) begin
        state_d = mode_i ? AUTO : MANUAL;
        if (mode_i) begin
          pegs_d = INIT;
          cnt_d = '0;
        end
      end
      AUTO: if (cnt_q == LAST) state_d = DONE;
      DONE: if (start_i) state_d = IDLE;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pegs_q <= INIT;
      cnt_q <= '0;
      rv_q <= 1'b0;
      rl_q <= 1'b0;
      re_q <= ERR_OK;
    end else begin
      state_q <= state_d;
      pegs_q <= pegs_d;
      cnt_q <= cnt_d;
      rv_q <= rv_d;
      rl_q <= rl_d;
      re_q <= re_d;
    end
  end
  // every disk sits on exactly one peg
  always_comb begin
    seen = '0;
    dup = '0;
    for (int p = 0; p < P; p++) begin
      dup |= seen & pegs_q[p];
      seen |= pegs_q[p];
    end
  end
  always_ff @(posedge clk) if (!rst) assert (&seen && dup == '0);
  assign mv_ready_o = state_q == MANUAL;
  assign busy_o = state_q == AUTO;
  assign solved_o = &pegs_q[TGT];
  assign peg_state_o = pegs_q;
  assign move_cnt_o = cnt_q;
  assign rsp_valid_o = rv_q;
  assign rsp_legal_o = rl_q;
  assign rsp_err_o = re_q;
endmodule

// File: tb/tb_hanoi_engine.sv
// tb_hanoi_engine: three engine variants checked each cycle against a disk-position model
module tb_hanoi_engine;
  logic clk = 0, rst = 1, mode = 0, mv_valid = 0;
  logic [2:0] start = '0;
  logic [1:0] mv_from = '0, mv_to = '0;
  logic [31:0] obs [3][8];
  int nvec = 0, nbad = 0;
  int NS [3] = '{3, 4, 3};
  int NP [3] = '{3, 3, 4};
  int pos [3][8];
  int cnt [3], md [3], rv [3], rl [3], re [3];
  string nm [8] = '{"peg_state", "move_cnt", "solved", "busy", "mv_ready", "rsp_valid", "rsp_legal", "rsp_err"};
  int ff [7] = '{0, 0, 3, 0, 1, 1, 0};
  int tt [7] = '{3, 1, 1, 3, 0, 3, 3};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int GS = g == 1 ? 4 : 3;
    localparam int GP = g == 2 ? 4 : 3;
    logic [GP*GS-1:0] ps;
    logic [GS:0] mc;
    logic sv, bz, rdy, rv_o, rl_o;
    logic [1:0] re_o;
    hanoi_engine #(.S(GS), .P(GP)) dut (
      .clk(clk), .rst(rst), .mode_i(mode), .start_i(start[g]),
      .mv_valid_i(mv_valid), .mv_ready_o(rdy), .mv_from_i(mv_from), .mv_to_i(mv_to),
      .rsp_valid_o(rv_o), .rsp_legal_o(rl_o), .rsp_err_o(re_o),
      .peg_state_o(ps), .move_cnt_o(mc), .solved_o(sv), .busy_o(bz)
    );
    assign obs[g][0] = 32'(ps);
    assign obs[g][1] = 32'(mc);
    assign obs[g][2] = 32'(sv);
    assign obs[g][3] = 32'(bz);
    assign obs[g][4] = 32'(rdy);
    assign obs[g][5] = 32'(rv_o);
    assign obs[g][6] = 32'(rl_o);
    assign obs[g][7] = 32'(re_o);
  end
  function automatic int topd(int g, int p);
    for (int d = 0; d < NS[g]; d++) if (pos[g][d] == p) return d;
    return NS[g];
  endfunction
  function automatic int lab(int l, int gl, int np);
    return l == 0 ? 0 : l == gl ? np - 1 : 1;
  endfunction
  task automatic apply(int g, int f, int t);
    int d, e;
    d = topd(g, f);
    e = (f == t || f >= NP[g] || t >= NP[g]) ? 3 : d == NS[g] ? 1 : topd(g, t) < d ? 2 : 0;
    rv[g] = 1;
    re[g] = e;
    rl[g] = e == 0;
    if (e == 0) begin
      pos[g][d] = t;
      if (cnt[g] < (1 << (NS[g] + 1)) - 1) cnt[g]++;
    end
  endtask
  // Auto moves come from the closed-form binary solution on labels 0/1/2, mapped onto real pegs
  task automatic model_step();
    int m, f, t, gl;
    for (int g = 0; g < 3; g++) begin
      rv[g] = 0; rl[g] = 0; re[g] = 0;
      if (rst) begin
        md[g] = 0; cnt[g] = 0;
        for (int d = 0; d < 8; d++) pos[g][d] = 0;
      end else case (md[g])
        0: if (start[g]) begin
          md[g] = mode ? 2 : 1;
          if (mode) begin
            cnt[g] = 0;
            for (int d = 0; d < 8; d++) pos[g][d] = 0;
          end
        end
        1: if (mv_valid) apply(g, int'(mv_from), int'(mv_to));
        2: begin
          m = cnt[g] + 1;
          f = (m & (m - 1)) % 3;
          t = ((m | (m - 1)) + 1) % 3;
          gl = (NS[g] % 2 == 1) ? 2 : 1;
          apply(g, lab(f, gl, NP[g]), lab(t, gl, NP[g]));
          if (cnt[g] == (1 << NS[g]) - 1) md[g] = 3;
        end
        3: if (start[g]) md[g] = 0;
        default: ;
      endcase
    end
  endtask
  function automatic logic [31:0] ex(int g, int k);
    logic [31:0] v;
    v = 0;
    case (k)
      0: for (int d = 0; d < NS[g]; d++) v |= 32'(1) << (pos[g][d] * NS[g] + d);
      1: v = cnt[g];
      2: begin
        v = 1;
        for (int d = 0; d < NS[g]; d++) if (pos[g][d] != NP[g] - 1) v = 0;
      end
      3: v = 32'(md[g] == 2);
      4: v = 32'(md[g] == 1);
      5: v = rv[g];
      6: v = rl[g];
      default: v = re[g];
    endcase
    return v;
  endfunction
  task automatic compare_all();
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 8; k++) begin
        nvec++;
        if (obs[g][k] !== ex(g, k)) begin
          nbad++;
          $display("FAIL u%0d.%s @%0t: got %0h want %0h", g, nm[k], $time, obs[g][k], ex(g, k));
        end
      end
  endtask
  task automatic lit(string s, int g, int k, logic [31:0] w);
    nvec++;
    if (obs[g][k] !== w) begin
      nbad++;
      $display("FAIL %s: u%0d.%s got %0h want %0h", s, g, nm[k], obs[g][k], w);
    end
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask
  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic mv(int f, int t);
    mv_valid = 1; mv_from = 2'(f); mv_to = 2'(t);
    step();
    mv_valid = 0;
  endtask
  task automatic go(int g, bit m);
    start[g] = 1; mode = m;
    step();
    start = '0; mode = 0;
  endtask
  initial begin
    steps(2);
    rst = 0;
    lit("rst_pegs", 0, 0, 7); lit("rst_cnt", 0, 1, 0); lit("rst_ready", 0, 4, 0);
    lit("rst_solved", 0, 2, 0); lit("rst_busy", 0, 3, 0);
    start[0] = 1; start[1] = 1; mode = 1;
    step();
    start = '0; mode = 0;
    lit("auto_busy", 0, 3, 1);
    step();
    lit("auto1_s3", 0, 0, 70); lit("auto1_s4", 1, 0, 30); lit("auto1_valid", 0, 5, 1);
    steps(6);
    lit("s3_pegs", 0, 0, 448); lit("s3_cnt", 0, 1, 7); lit("s3_solved", 0, 2, 1); lit("s3_busy", 0, 3, 0);
    steps(8);
    lit("s4_pegs", 1, 0, 3840); lit("s4_cnt", 1, 1, 15); lit("s4_solved", 1, 2, 1); lit("s4_busy", 1, 3, 0);
    go(0, 0);
    lit("idle_pegs", 0, 0, 448); lit("idle_ready", 0, 4, 0);
    go(0, 1);
    steps(2);
    rst = 1;
    step();
    rst = 0;
    lit("rr_pegs", 0, 0, 7); lit("rr_cnt", 0, 1, 0); lit("rr_busy", 0, 3, 0); lit("rr_valid", 0, 5, 0);
    go(2, 0);
    lit("p4_ready", 2, 4, 1);
    for (int i = 0; i < 7; i++) mv(ff[i], tt[i]);
    lit("p4_solved", 2, 2, 1); lit("p4_cnt", 2, 1, 7); lit("p4_pegs", 2, 0, 3584);
    mv(3, 0);
    lit("p4_unsolve", 2, 2, 0); lit("p4_cnt8", 2, 1, 8); lit("p4_pegs8", 2, 0, 3073); lit("p4_legal", 2, 6, 1);
    go(0, 0);
    mv(0, 2);
    lit("m_pegs", 0, 0, 70); lit("m_valid", 0, 5, 1); lit("m_legal", 0, 6, 1); lit("m_cnt", 0, 1, 1);
    mv(0, 2); lit("m_size", 0, 7, 2); lit("m_size_lg", 0, 6, 0);
    mv(1, 0); lit("m_empty", 0, 7, 1);
    mv(0, 0); lit("m_same", 0, 7, 3);
    mv(3, 1); lit("m_range", 0, 7, 3);
    lit("m_keep_pegs", 0, 0, 70); lit("m_keep_cnt", 0, 1, 1);
    for (int i = 0; i < 16; i++) mv(i % 2 ? 1 : 2, i % 2 ? 2 : 1);
    lit("sat_cnt", 0, 1, 15); lit("sat_legal", 0, 6, 1);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/hanoi_engine.md
Name: hanoi_engine

Overview:
- Parametrised Tower-of-Hanoi state engine: S disks on P pegs, held as per-peg occupancy bitmasks.
- Manual mode: accepts move requests over a valid/ready handshake and checks each move in hardware. Illegal moves are rejected with an error code, not excluded by the environment.
- Auto mode: an iterative solver generates the optimal 2^S-1 move sequence from peg 0 to peg TGT, one move per cycle.
- Serves as the puzzle core for formal and simulation benches; move counter and solved flag feed covers.

Parameters:
- S, 3, number of disks (2..8).
- P, 3, number of pegs (3..4).
- TGT, P-1, target peg index for solved detection and auto mode (1..P-1).
- PW, $clog2(P), peg index width.
- CW, S+1, move counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mode  in  1  0 = manual, 1 = auto; sampled only in IDLE
- start  in  1  pulse: begin auto solve (mode=1) or enter manual (mode=0)
- mv_valid  in  1  manual move request valid
- mv_ready  out  1  engine accepts manual move
- mv_from  in  PW  source peg
- mv_to  in  PW  destination peg
- rsp_valid  out  1  one-cycle pulse: a move was processed
- rsp_legal  out  1  processed move was legal and applied
- rsp_err  out  2  0 ok, 1 source empty, 2 larger onto smaller, 3 bad peg
- peg_state  out  P*S  peg p occupies bits [p*S +: S]; bit i = disk of size i+1 (bit 0 smallest)
- move_cnt  out  CW  legal moves applied since init, saturating at all-ones
- solved  out  1  peg TGT holds all S disks
- busy  out  1  auto solve in progress

Behaviour:
- Reset (clk, rst: synchronous, active-high): state IDLE; peg 0 = all ones, other pegs 0; move_cnt 0; rsp_valid/rsp_legal 0; rsp_err 0; busy 0; mv_ready 0.
- Top disk of a peg is its lowest set bit. A move is legal iff:
  - from != to, and both indices < P;
  - from is non-empty;
  - to is empty, or top(from) < top(to).
- Error priority on an illegal move: bad peg (3) > source empty (1) > larger onto smaller (2).
- FSM states: IDLE, MANUAL, AUTO, DONE.
- IDLE:
  - start & mode=0 -> MANUAL; pegs and counter are kept.
  - start & mode=1 -> AUTO; next cycle pegs are re-initialised (all disks on peg 0), move_cnt=0, busy=1.
- MANUAL:
  - mv_ready=1. A request is accepted when mv_valid & mv_ready.
  - Next cycle: rsp_valid=1. If legal, the top disk moves from -> to, move_cnt increments, rsp_legal=1, rsp_err=0. If illegal, pegs and counter are unchanged, rsp_legal=0, rsp_err set.
  - Moves continue to be accepted after solved. start is ignored. Only rst leaves MANUAL.
- AUTO:
  - mv_ready=0. Exactly one move per cycle, each reported with rsp_valid=1, rsp_legal=1.
  - Odd-numbered moves (1st, 3rd, ...) move the smallest disk cyclically.
    - S even: 0 -> AUX -> TGT -> 0.
    - S odd: 0 -> TGT -> AUX -> 0.
    - AUX is the lowest peg index not in {0, TGT}.
  - Even-numbered moves: the single legal move between the two of {0, AUX, TGT} not holding the smallest disk.
  - Pegs outside {0, AUX, TGT} stay empty.
  - When move_cnt reaches 2^S-1 (solved=1): -> DONE, busy=0.
- DONE:
  - Holds state; rsp_valid=0.
  - start -> IDLE with pegs untouched.
- solved is combinational from the registered pegs.
- rsp_* are registered, one-cycle latency from acceptance.
- Invariant, checked by assertion: the pegs partition the disk set. Per bit position, exactly one peg has the bit set.
- Reset mid-AUTO or mid-handshake: everything returns to reset values on the next edge; any in-flight response is dropped.
- move_cnt saturates and does not wrap.

Decomposition:
- Package hanoi_pkg holds:
  - typedef err_e (ERR_OK, ERR_EMPTY, ERR_SIZE, ERR_PEG);
  - typedef state_e;
  - function top_disk (one-hot lowest set bit of a peg mask).
- Sub-module hanoi_move_check: purely combinational. Takes peg masks, from and to; produces legal, err and the updated from/to masks. It is instantiated once and shared by the manual path and the auto path.

Test Plan:
- Reset, S=3 P=3 -> peg_state = {000,000,111}, move_cnt=0, mv_ready=0, solved=0.
- start mode=0, move 0->2 -> next cycle rsp_valid=1, rsp_legal=1, peg0=110, peg2=001, move_cnt=1.
- From the previous state, move 0->2 -> rsp_err=2. Move 1->0 -> rsp_err=1. Move 0->0 -> rsp_err=3. In all three cases pegs and move_cnt=1 are unchanged.
- start mode=1 (S=3) -> 7 consecutive rsp_valid pulses, first move 0->2, then peg2=111, move_cnt=7, solved=1, busy=0, state DONE. Repeat with S=4: 15 moves, first move 0->1.
- P=4, S=3, manual: seven legal moves solving onto peg 3 -> solved=1, move_cnt=7. A further legal move 3->0 -> accepted, solved=0, move_cnt=8.
- rst asserted at the 3rd auto move -> next cycle peg0=111, others 0, move_cnt=0, busy=0, rsp_valid=0.
